// File: rtl/bsg_counter_window_pkg.sv
// Shared types for the windowed counter sampler.
// Holds the FSM state enum and the timer width helper.
package bsg_counter_window_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int timer_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with clear: next = (clear ? 0 : count) + up.
// Paired with the window sampler, which drives clear and up.
module bsg_counter_clear_up #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  // clear and up in one cycle leaves the count at one
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else begin
      count_o <= (clear_i ? '0 : count_o) + width_p'(up_i);
    end
  end

endmodule

// File: rtl/bsg_one_fifo_drop.sv
// One-entry valid/ready holding register.
// A write into a full, stalled entry is refused and flagged on drop_o.
module bsg_one_fifo_drop #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               ready_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               drop_o
);

  logic load;

  assign load   = v_i & (~v_o | ready_i);
  assign drop_o = v_i & v_o & ~ready_i;

  // entry fills on load, empties on accept without a refill
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else begin
      if (load) begin
        v_o    <= 1'b1;
        data_o <= data_i;
      end else if (ready_i) begin
        v_o    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bsg_counter_window_sampler.sv
// Windowed sampler in front of a clear/up counter.
// Snapshots each window total and clears without losing the boundary event.
module bsg_counter_window_sampler
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int window_p     = 1024,
  parameter int drop_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    event_i,
  input  logic [width_p-1:0]      count_i,
  output logic                    up_o,
  output logic                    clear_o,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    ready_i,
  output logic [drop_width_p-1:0] dropped_o
);

  localparam int timer_w_lp = timer_width(window_p);
  localparam logic [timer_w_lp-1:0] last_lp =
    timer_w_lp'(window_p - 1);

  state_e                state;
  state_e                state_n;
  logic [timer_w_lp-1:0] timer;
  logic [timer_w_lp-1:0] timer_n;
  logic                  boundary;
  logic                  drop;

  assign boundary = (state == RUN) && (timer == last_lp);

  // state and window timer registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // next state, timer and counter controls
  always_comb begin
    state_n = state;
    timer_n = '0;
    clear_o = 1'b1;
    up_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_i) state_n = RUN;
      end
      RUN: begin
        clear_o = boundary;
        up_o    = event_i;
        timer_n = boundary ? '0 : timer + timer_w_lp'(1);
        if (!en_i) begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  bsg_one_fifo_drop #(
    .width_p(width_p)
  ) out_buf (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (boundary),
    .data_i   (count_i),
    .ready_i  (ready_i),
    .v_o      (v_o),
    .data_o   (data_o),
    .drop_o   (drop)
  );

  // saturating count of refused snapshots
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dropped_o <= '0;
    end else if (drop && !(&dropped_o)) begin
      dropped_o <= dropped_o + drop_width_p'(1);
    end
  end

endmodule
